ab_responder: RTL and testbench

- Responder end of the a/b request-response handshake. Every cycle in which `a` is sampled high is answered by `b` high within MIN_DLY..MAX_DLY cycles.
- The response delay is programmable, and a `hold` input may defer the response up to the hard deadline.
- Sits opposite any initiator whose contract is checked by the concurrent property `@(posedge clk) a |-> ##[MIN_DLY:MAX_DLY] b`. That property must never fail against this block.

---
 rtl/ab_resp_pkg.sv | 18 +
 rtl/ab_deadline_cnt.sv | 33 +++
 rtl/ab_responder.sv | 113 +++++++++++
 tb/tb_ab_responder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ab_resp_pkg.sv
// Shared types, defaults and helpers for the a/b responder.
package ab_resp_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int MIN_DLY_DEF = 1;
  localparam int MAX_DLY_DEF = 5;

  // Effective response latency: the requested delay forced into [lo, hi].
  function automatic int clamp_dly(input int v, input int lo, input int hi);
    int r;
    r = v;
    if (v < lo) r = lo;
    if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/ab_deadline_cnt.sv
// Elapsed-cycle counter for a pending response. The compare outputs answer
// "if b is written at this edge, when will it be seen": the counter holds
// j-1 at edge T0+j, so b written now is seen at T0+cnt+2.
module ab_deadline_cnt
  import ab_resp_pkg::*;
#(
  parameter int CNT_W   = 3,
  parameter int MAX_DLY = MAX_DLY_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] eff,
  output logic             min_reached,
  output logic             deadline_now
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_seen_at;

  // Counter: cleared at acceptance, advances every cycle spent waiting.
  always_ff @(posedge clk) begin
    if (!rst_n)   r_cnt <= '0;
    else if (clr) r_cnt <= '0;
    else if (inc) r_cnt <= r_cnt + 1'b1;
  end

  assign w_seen_at    = {1'b0, r_cnt} + (CNT_W+1)'(2);
  assign min_reached  = (w_seen_at >= {1'b0, eff});
  assign deadline_now = (w_seen_at >= (CNT_W+1)'(MAX_DLY));

endmodule

// File: rtl/ab_responder.sv
// Responder side of the a/b handshake: answers each accepted request with b
// inside [eff, MAX_DLY] cycles; hold defers b but never past the deadline.
module ab_responder
  import ab_resp_pkg::*;
#(
  parameter int MIN_DLY = MIN_DLY_DEF,
  parameter int MAX_DLY = MAX_DLY_DEF,
  parameter int CNT_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic [CNT_W-1:0] dly_cfg,
  input  logic             hold,
  output logic             b,
  output logic             busy,
  output logic             deadline_hit,
  output logic [7:0]       resp_cnt
);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_eff, w_eff_acc;
  logic             r_b, r_dh;
  logic [7:0]       r_resp_cnt;
  logic             w_fire, w_drop, w_dh_set, w_clr, w_inc;
  logic             w_min, w_dl;

  assign w_eff_acc = CNT_W'(clamp_dly(int'(dly_cfg), MIN_DLY, MAX_DLY));

  ab_deadline_cnt #(.CNT_W(CNT_W), .MAX_DLY(MAX_DLY)) u_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (w_clr),
    .inc          (w_inc),
    .eff          (r_eff),
    .min_reached  (w_min),
    .deadline_now (w_dl)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state plus the b set/clear, deadline and counter controls.
  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    w_drop      = 1'b0;
    w_dh_set    = 1'b0;
    w_clr       = 1'b0;
    w_inc       = 1'b0;
    case (r_state)
      IDLE: begin
        if (a) begin
          w_clr = 1'b1;
          // With a one-cycle deadline the acceptance edge is also the
          // deadline edge, so hold cannot defer b there.
          if (w_eff_acc == CNT_W'(1) && (!hold || MAX_DLY == 1)) begin
            w_fire      = 1'b1;
            w_dh_set    = hold;
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        // a is ignored here: the response is owed for the accepted request
        // and it also covers any later requests.
        w_inc = 1'b1;
        if (w_dl) begin
          w_fire      = 1'b1;
          w_dh_set    = hold;
          w_state_nxt = RESP;
        end else if (w_min && !hold) begin
          w_fire      = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (!a) begin
          w_drop      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output registers: b, deadline pulse, response count, latched eff.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_b        <= 1'b0;
      r_dh       <= 1'b0;
      r_resp_cnt <= '0;
      r_eff      <= '0;
    end else begin
      r_dh <= w_dh_set;
      if (w_clr)       r_eff <= w_eff_acc;
      if (w_fire)      r_b   <= 1'b1;
      else if (w_drop) r_b   <= 1'b0;
      if (w_fire)      r_resp_cnt <= r_resp_cnt + 8'd1;
    end
  end

  assign b            = r_b;
  assign busy         = (r_state != IDLE);
  assign deadline_hit = r_dh;
  assign resp_cnt     = r_resp_cnt;

endmodule

// File: tb/tb_ab_responder.sv
// Scoreboard bench for ab_responder: each request pushes its expected b
// sample edge, deadline flag and count; the b rising edge pops and compares.
module tb_ab_responder;

  localparam int MIN = 1;
  localparam int MAX = 5;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a = 1'b0;
  logic [CW-1:0] dly_cfg = '0;
  logic          hold = 1'b0;
  logic          b, busy, deadline_hit;
  logic [7:0]    resp_cnt;

  typedef struct {
    int         edge_no;
    bit         dh;
    logic [7:0] cnt;
  } sb_t;

  sb_t        q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic       prev_b = 1'b0;

  ab_responder #(.MIN_DLY(MIN), .MAX_DLY(MAX), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a            (a),
    .dly_cfg      (dly_cfg),
    .hold         (hold),
    .b            (b),
    .busy         (busy),
    .deadline_hit (deadline_hit),
    .resp_cnt     (resp_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  property p_ab;
    @(posedge clk) disable iff (!rst_n) a |-> ##[MIN:MAX] b;
  endproperty
  a_ab: assert property (p_ab) else chk("assert_ab", 32'(b), 32'(1));

  // Scoreboard consumer: first cycle b is high means a new response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (b && !prev_b) begin
        if (q.size() == 0) begin
          chk("unexpected_b", 32'(b), 32'(0));
        end else begin
          sb_t e;
          e = q.pop_front();
          chk("b_edge", 32'(cyc + 1), 32'(e.edge_no));
          chk("dh_at_b", 32'(deadline_hit), 32'(e.dh));
          chk("cnt_at_b", 32'(resp_cnt), 32'(e.cnt));
        end
      end else if (deadline_hit) begin
        chk("dh_stray", 32'(deadline_hit), 32'(0));
      end
    end
    prev_b = b;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected latency k (b sampled at T0+k) given hold is high at edges
  // T0 .. T0+hrel-1: earliest k >= eff whose write edge T0+k-1 sees hold
  // low, otherwise forced at MAX.
  task automatic model(input int cfg, input int hrel, output int k, output bit dh);
    int  eff;
    bit  found;
    eff = (cfg < MIN) ? MIN : (cfg > MAX) ? MAX : cfg;
    found = 1'b0;
    k  = MAX;
    dh = (MAX - 1 < hrel);
    for (int kk = eff; kk <= MAX; kk++) begin
      if (!found && !(kk - 1 < hrel)) begin
        found = 1'b1;
        k     = kk;
        dh    = 1'b0;
      end
    end
  endtask

  // One request: a high for a_len sampled edges, hold high for the first
  // hrel edges; dly_cfg scrambled after acceptance.
  task automatic run_req(input int cfg, input int a_len, input int hrel);
    int  k, last;
    bit  dh;
    sb_t e;
    model(cfg, hrel, k, dh);
    exp_cnt++;
    e.edge_no = cyc + 1 + k;
    e.dh      = dh;
    e.cnt     = exp_cnt;
    q.push_back(e);
    last = (k > a_len) ? k : a_len;
    for (int j = 0; j <= last + 1; j++) begin
      a       = (j < a_len);
      hold    = (j < hrel);
      dly_cfg = (j == 0) ? CW'(cfg) : CW'($urandom_range(0, 7));
      tick();
      chk("b_level", 32'(b), 32'((j + 1 >= k) && (j + 1 <= last)));
      chk("busy", 32'(busy), 32'(j + 1 <= last));
    end
    a    = 1'b0;
    hold = 1'b0;
    chk("resp_cnt", 32'(resp_cnt), 32'(exp_cnt));
  endtask

  initial begin
    // Reset values.
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_b", 32'(b), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_dh", 32'(deadline_hit), 32'(0));
    chk("rst_cnt", 32'(resp_cnt), 32'(0));
    rst_n = 1'b1;
    tick();

    run_req(3, 6, 0);   // nominal
    run_req(0, 7, 0);   // clamp low -> T0+1
    run_req(7, 7, 0);   // clamp high -> T0+5
    run_req(2, 1, 99);  // hold to deadline
    run_req(2, 1, 3);   // hold released at T0+3
    run_req(4, 1, 0);   // one-cycle request, one-cycle b
    tick();
    run_req(1, 2, 1);   // eff=1 deferred one cycle by hold
    for (int i = 0; i < 10; i++)
      run_req($urandom_range(0, 7), $urandom_range(1, 7), $urandom_range(0, 6));

    // Reset while waiting: the pending response is dropped.
    a = 1'b1; dly_cfg = 3'd5; hold = 1'b0;
    tick();
    a = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    exp_cnt = 8'd0;
    chk("mid_rst_b", 32'(b), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_dh", 32'(deadline_hit), 32'(0));
    chk("mid_rst_cnt", 32'(resp_cnt), 32'(0));
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mid_rst_quiet", 32'(b), 32'(0));
    end
    run_req(3, 2, 0);   // fresh request after the aborted one
    chk("sb_drain", 32'(q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
